// File: rtl/dog_scheduler_pkg.sv
// Shared types and widths for the DoG/extrema sweep scheduler.
// Used by dog_scheduler, its watchdog and the worker-side interface.
package dog_sched_pkg;

   localparam int OCT_W   = 2;
   localparam int SCALE_W = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LAUNCH,
      WAIT_ACK,
      RUN,
      ADVANCE,
      DONE
   } sched_state_t;

   // Width needed to hold the octave-0 side length itself, not just its index range.
   function automatic int DIM_W(input int dimension);
      return $clog2(dimension) + 1;
   endfunction

endpackage

// File: rtl/dog_scheduler_if.sv
// Worker launch handshake plus BRAM read-mux selects between the scheduler
// (master) and the extrema worker / pyramid mux (slave).
interface dog_scheduler_if #(
   parameter int DIMENSION = 64
);
   localparam int DW = dog_sched_pkg::DIM_W(DIMENSION);

   logic                               worker_start;
   logic                               worker_busy;
   logic [dog_sched_pkg::OCT_W-1:0]    octave_out;
   logic [dog_sched_pkg::SCALE_W-1:0]  sharp_sel;
   logic [dog_sched_pkg::SCALE_W-1:0]  fuzzy_sel;
   logic [DW-1:0]                      dim_out;

   modport master (
      output worker_start, octave_out, sharp_sel, fuzzy_sel, dim_out,
      input  worker_busy
   );

   modport slave (
      input  worker_start, octave_out, sharp_sel, fuzzy_sel, dim_out,
      output worker_busy
   );

endinterface

// File: rtl/dog_scheduler_watchdog.sv
// Loadable up-counter with clear and terminal-count flag; bounds how long the
// scheduler waits on the worker. Only instantiated when DOG_SCHED_TIMEOUT_EN is set.
module sched_watchdog #(
   parameter  int LIMIT = 16384,
   localparam int CNT_W = $clog2(LIMIT) + 1
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_count;

   // Terminal count fires on the LIMIT-th enabled cycle after a load of zero.
   assign o_tc = i_en && (r_count == CNT_W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && !o_tc) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/dog_scheduler.sv
// Walks every octave and adjacent scale pair, launching the extrema worker once per pair.
// Optional worker watchdog enabled by defining DOG_SCHED_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for start_in; selects hold last values
// SETUP    | selects stable one cycle for BRAM mux / read latency
// LAUNCH   | worker_start pulsed
// WAIT_ACK | waiting for worker_busy to rise
// RUN      | worker busy; waiting for it to fall
// ADVANCE  | step pair, then octave; or finish
// DONE     | done pulsed, back to IDLE
module dog_scheduler
   import dog_sched_pkg::*;
#(
   parameter int NUM_OCTAVES    = 3,
   parameter int NUM_SCALES     = 4,
   parameter int DIMENSION      = 64,
   parameter int TIMEOUT_CYCLES = 16384
) (
   input  logic            clk,
   input  logic            rst_in,
   input  logic            start_in,
   dog_scheduler_if.master wk,
   output logic            busy,
   output logic            done,
   output logic            error_out
);

   localparam int                 DW        = DIM_W(DIMENSION);
   localparam logic [SCALE_W-1:0] PAIR_LAST = SCALE_W'(NUM_SCALES - 2);
   localparam logic [OCT_W-1:0]   OCT_LAST  = OCT_W'(NUM_OCTAVES - 1);
   localparam logic [DW-1:0]      DIM_FULL  = DW'(DIMENSION);

   if (NUM_OCTAVES < 1 || NUM_OCTAVES > 4) begin : g_bad_octaves
      $error("dog_scheduler: NUM_OCTAVES must be 1..4");
   end
   if (NUM_SCALES < 2 || NUM_SCALES > 4) begin : g_bad_scales
      $error("dog_scheduler: NUM_SCALES must be 2..4");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("dog_scheduler: TIMEOUT_CYCLES must be at least 2");
   end

   sched_state_t        r_state;
   logic [OCT_W-1:0]    r_octave;
   logic [SCALE_W-1:0]  r_sharp;
   logic [SCALE_W-1:0]  r_fuzzy;
   logic [DW-1:0]       r_dim;
   logic                r_worker_start;
   logic                r_busy;
   logic                r_done;
   logic                w_start_acc;
   logic                w_timeout;

   assign w_start_acc = (r_state == IDLE) && start_in;

`ifdef DOG_SCHED_TIMEOUT_EN
   logic w_wd_en;
   logic w_wd_tc;
   logic r_error;

   assign w_wd_en = (r_state == WAIT_ACK) || (r_state == RUN);

   sched_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .rst_in     (rst_in),
      .i_clr      (r_state == IDLE),
      .i_load     (r_state == LAUNCH),
      .i_load_val ('0),
      .i_en       (w_wd_en),
      .o_tc       (w_wd_tc)
   );

   assign w_timeout = w_wd_tc;

   // Sticky until the next accepted start so firmware can read it after done.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_error <= 1'b0;
      end else if (w_start_acc) begin
         r_error <= 1'b0;
      end else if (w_timeout) begin
         r_error <= 1'b1;
      end
   end

   assign error_out = r_error;
`else
   assign w_timeout = 1'b0;
   assign error_out = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_state        <= IDLE;
         r_octave       <= '0;
         r_sharp        <= '0;
         r_fuzzy        <= SCALE_W'(1);
         r_dim          <= DIM_FULL;
         r_worker_start <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_worker_start <= 1'b0;
         r_done         <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_acc) begin
                  r_state  <= SETUP;
                  r_octave <= '0;
                  r_sharp  <= '0;
                  r_fuzzy  <= SCALE_W'(1);
                  r_dim    <= DIM_FULL;
                  r_busy   <= 1'b1;
               end
            end
            SETUP: begin
               r_state        <= LAUNCH;
               r_worker_start <= 1'b1;
            end
            LAUNCH: begin
               r_state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (w_timeout) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else if (wk.worker_busy) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_timeout) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else if (!wk.worker_busy) begin
                  r_state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (r_sharp < PAIR_LAST) begin
                  r_sharp <= r_sharp + 1'b1;
                  r_fuzzy <= r_fuzzy + 1'b1;
                  r_state <= SETUP;
               end else begin
                  r_sharp <= '0;
                  r_fuzzy <= SCALE_W'(1);
                  if (r_octave < OCT_LAST) begin
                     r_octave <= r_octave + 1'b1;
                     r_dim    <= r_dim >> 1;
                     r_state  <= SETUP;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign wk.worker_start = r_worker_start;
   assign wk.octave_out   = r_octave;
   assign wk.sharp_sel    = r_sharp;
   assign wk.fuzzy_sel    = r_fuzzy;
   assign wk.dim_out      = r_dim;
   assign busy            = r_busy;
   assign done            = r_done;

endmodule

// File: tb/tb_dog_scheduler.sv
// Bench for dog_scheduler: cycle-accurate event-time model of a sweep checked every
// cycle, randomized worker behaviour, plus literal checks that pin the model.
module tb_dog_scheduler;

   localparam int NO    = 3;
   localparam int NS    = 4;
   localparam int DIM   = 64;
   localparam int TO    = 32;
   localparam int NPAIR = NS - 1;
   localparam int TOTAL = NO * NPAIR;

   logic clk      = 1'b0;
   logic rst_in   = 1'b1;
   logic start_in = 1'b0;
   logic busy;
   logic done;
   logic error_out;

   dog_scheduler_if #(.DIMENSION(DIM)) wif ();

   dog_scheduler #(
      .NUM_OCTAVES   (NO),
      .NUM_SCALES    (NS),
      .DIMENSION     (DIM),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk      (clk),
      .rst_in   (rst_in),
      .start_in (start_in),
      .wk       (wif),
      .busy     (busy),
      .done     (done),
      .error_out(error_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int ws_count = 0;
   int done_count = 0;
   int last_done_c = -1;
   int st_cyc = 0;

   typedef struct {
      int o;
      int s;
      int f;
      int d;
      int c;
   } launch_t;
   launch_t lg[$];

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Worker model: on each launch a plan of busy values is built, entry 0 covering the LAUNCH cycle.
   int wmode = 0;
   int w_ack = 1;
   int w_run = 10;
   int w_gap = 1;
   bit w_rand = 1'b0;
   bit plan[$];

   initial begin
      wif.worker_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_in) begin
            plan.delete();
            wif.worker_busy = 1'b0;
         end else begin
            if (wif.worker_start) begin
               int md, a, r, g;
               md = wmode; a = w_ack; r = w_run; g = w_gap;
               if (w_rand) begin
                  md = $urandom_range(0, 2);
                  a  = $urandom_range(1, 4);
                  r  = $urandom_range(2, 8);
                  g  = $urandom_range(1, 3);
               end
               plan.delete();
               case (md)
                  0: begin
                     repeat (a) plan.push_back(1'b0);
                     repeat (r) plan.push_back(1'b1);
                  end
                  1: repeat (r) plan.push_back(1'b1);
                  2: begin
                     plan.push_back(1'b1);
                     repeat (g) plan.push_back(1'b0);
                     repeat (r) plan.push_back(1'b1);
                  end
                  default: ;
               endcase
            end
            wif.worker_busy = (plan.size() > 0) ? plan.pop_front() : 1'b0;
         end
      end
   end

   // Reference model in terms of event times: launch at start+2, next launch 3 cycles
   // after the worker falls, done 2 cycles after the last fall, selects move 2 after a fall.
   bit e_busy = 1'b0;
   bit e_err = 1'b0;
   int e_oct = 0;
   int e_pair = 0;
   int pend_cyc = -1, pend_oct = 0, pend_pair = 0;
   int next_launch = -1, last_launch = -1, ack_cyc = -1, done_cyc = -1, err_cyc = -1;
   int launches = 0;
   bit waiting = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_in) begin
            e_busy = 1'b0; e_err = 1'b0; e_oct = 0; e_pair = 0;
            pend_cyc = -1; next_launch = -1; done_cyc = -1; err_cyc = -1;
            waiting = 1'b0; launches = 0;
         end else begin
            int pc;
            bit to;
            pc = cyc - 1;
            to = 1'b0;
            if (start_in && !e_busy) begin
               e_busy = 1'b1; e_err = 1'b0; e_oct = 0; e_pair = 0;
               launches = 0; next_launch = cyc + 1; done_cyc = -1; err_cyc = -1;
               pend_cyc = -1; waiting = 1'b0;
            end
            if (waiting && pc > last_launch) begin
`ifdef DOG_SCHED_TIMEOUT_EN
               if (pc - last_launch >= TO) to = 1'b1;
`endif
               if (to) begin
                  waiting = 1'b0; done_cyc = cyc; err_cyc = cyc;
               end else if (ack_cyc < 0) begin
                  if (wif.worker_busy) ack_cyc = pc;
               end else if (!wif.worker_busy) begin
                  waiting = 1'b0;
                  pend_cyc = pc + 2;
                  if (launches == TOTAL) begin
                     done_cyc = pc + 2; pend_oct = NO - 1; pend_pair = 0;
                  end else begin
                     next_launch = pc + 3; pend_oct = launches / NPAIR; pend_pair = launches % NPAIR;
                  end
               end
            end
            if (pend_cyc == cyc) begin
               e_oct = pend_oct; e_pair = pend_pair;
            end
            if (err_cyc == cyc) e_err = 1'b1;
            if (done_cyc >= 0 && cyc > done_cyc) e_busy = 1'b0;
         end
         chk("worker_start", int'(wif.worker_start), int'(cyc == next_launch));
         chk("done", int'(done), int'(cyc == done_cyc));
         chk("busy", int'(busy), int'(e_busy));
         chk("octave", int'(wif.octave_out), e_oct);
         chk("sharp", int'(wif.sharp_sel), e_pair);
         chk("fuzzy", int'(wif.fuzzy_sel), e_pair + 1);
         chk("dim", int'(wif.dim_out), DIM >> e_oct);
         chk("error", int'(error_out), int'(e_err));
         if (wif.worker_start) begin
            ws_count++;
            lg.push_back('{o: int'(wif.octave_out), s: int'(wif.sharp_sel),
                           f: int'(wif.fuzzy_sel), d: int'(wif.dim_out), c: cyc});
         end
         if (done) begin
            done_count++;
            last_done_c = cyc;
         end
         if (next_launch == cyc) begin
            launches++; last_launch = cyc; waiting = 1'b1; ack_cyc = -1; next_launch = -1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      st_cyc = cyc;
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = done_count;
      for (int i = 0; i < budget && done_count == d0; i++) @(negedge clk);
      if (done_count == d0) chk("done_wait_expired", 0, 1);
   endtask

   task automatic wait_launch_busy(input int base, input int n);
      int i;
      for (i = 0; i < 400 && !((ws_count - base) >= n && wif.worker_busy); i++) @(negedge clk);
      if (i >= 400) chk("launch_wait_expired", 0, 1);
   endtask

   task automatic rand_start_sweep(input int budget);
      int d0;
      d0 = done_count;
      for (int i = 0; i < budget && done_count == d0; i++) begin
         start_in = ($urandom_range(0, 7) == 0);
         @(negedge clk);
      end
      start_in = 1'b0;
      if (done_count == d0) chk("rand_done_expired", 0, 1);
   endtask

   task automatic check_idle_literals(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_wstart"}, int'(wif.worker_start), 0);
      chk({tag, "_octave"}, int'(wif.octave_out), 0);
      chk({tag, "_sharp"}, int'(wif.sharp_sel), 0);
      chk({tag, "_fuzzy"}, int'(wif.fuzzy_sel), 1);
      chk({tag, "_dim"}, int'(wif.dim_out), 64);
      chk({tag, "_error"}, int'(error_out), 0);
   endtask

   int lit_o[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
   int lit_s[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
   int lit_f[9] = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
   int lit_d[9] = '{64, 64, 64, 32, 32, 32, 16, 16, 16};

   initial begin
      int b, d;
      #2 rst_in = 1'b0;
      tick(3);
      check_idle_literals("in_reset");
      rst_in = 1'b1;
      tick(6);
      check_idle_literals("idle");

      // Deterministic sweep: ack after 1 cycle, run 10.
      w_rand = 1'b0; wmode = 0; w_ack = 1; w_run = 10;
      lg.delete(); b = ws_count; d = done_count;
      pulse_start();
      wait_done(1000);
      chk("sweep_launches", ws_count - b, 9);
      chk("sweep_dones", done_count - d, 1);
      for (int i = 0; i < lg.size() && i < 9; i++) begin
         chk("seq_octave", lg[i].o, lit_o[i]);
         chk("seq_sharp", lg[i].s, lit_s[i]);
         chk("seq_fuzzy", lg[i].f, lit_f[i]);
         chk("seq_dim", lg[i].d, lit_d[i]);
      end
      if (lg.size() >= 9) begin
         chk("first_launch_latency", lg[0].c - st_cyc, 2);
         chk("pair_spacing", lg[1].c - lg[0].c, 14);
         chk("done_after_last", last_done_c - lg[8].c, 13);
      end
      tick(1);
      chk("busy_drop", int'(busy), 0);

      // Start pulsed during RUN of pair 1 is ignored.
      lg.delete(); b = ws_count; d = done_count;
      pulse_start();
      wait_launch_busy(b, 2);
      tick(2);
      pulse_start();
      wait_done(1000);
      chk("ignore_launches", ws_count - b, 9);
      chk("ignore_dones", done_count - d, 1);
      tick(2);

      // Busy already high in LAUNCH for 5 cycles.
      wmode = 1; w_run = 5;
      lg.delete(); b = ws_count;
      pulse_start();
      wait_done(1000);
      chk("prehigh_launches", ws_count - b, 9);
      if (lg.size() >= 2) chk("prehigh_spacing", lg[1].c - lg[0].c, 8);
      tick(2);

      // Busy high only in LAUNCH, then a real run after a gap.
      wmode = 2; w_gap = 2; w_run = 3;
      lg.delete(); b = ws_count;
      pulse_start();
      wait_done(1000);
      chk("glitch_launches", ws_count - b, 9);
      if (lg.size() >= 2) chk("glitch_spacing", lg[1].c - lg[0].c, 9);
      tick(2);

      // Randomized worker timing with random start pulses while busy.
      w_rand = 1'b1;
      repeat (4) begin
         b = ws_count; d = done_count;
         pulse_start();
         rand_start_sweep(2000);
         chk("rand_launches", ws_count - b, 9);
         chk("rand_dones", done_count - d, 1);
         tick($urandom_range(1, 4));
      end
      w_rand = 1'b0;

      // Reset during RUN of octave 1.
      wmode = 0; w_ack = 1; w_run = 10;
      b = ws_count;
      pulse_start();
      wait_launch_busy(b, 4);
      tick(2);
      d = done_count;
      rst_in = 1'b0;
      #1;
      check_idle_literals("abort");
      tick(3);
      chk("abort_no_done", done_count - d, 0);
      rst_in = 1'b1;
      tick(2);
      lg.delete(); b = ws_count;
      pulse_start();
      wait_done(1000);
      chk("restart_launches", ws_count - b, 9);
      if (lg.size() > 0) begin
         chk("restart_octave", lg[0].o, 0);
         chk("restart_sharp", lg[0].s, 0);
         chk("restart_fuzzy", lg[0].f, 1);
         chk("restart_dim", lg[0].d, 64);
      end
      tick(2);

`ifdef DOG_SCHED_TIMEOUT_EN
      // Worker never acknowledges: watchdog fires.
      wmode = 3;
      lg.delete(); b = ws_count;
      pulse_start();
      wait_done(200);
      chk("timeout_launches", ws_count - b, 1);
      if (lg.size() > 0) chk("timeout_latency", last_done_c - lg[0].c, 33);
      chk("timeout_error", int'(error_out), 1);
      tick(3);
      chk("timeout_error_hold", int'(error_out), 1);
      wmode = 0;
      pulse_start();
      chk("timeout_error_clear", int'(error_out), 0);
      wait_done(1000);
      tick(2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_time_limit reached at cycle %0d", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/dog_scheduler.md
# dog_scheduler

Sequencer for the extrema/DoG worker. On a start pulse it walks every octave and every adjacent scale pair of the Gaussian pyramid, drives the scale and octave selects to the BRAM read mux, launches the worker once per pair, and waits for it to finish. It sits between the top-level SIFT control FSM and the single extrema worker instance.

## Interface
Parameters:
- NUM_OCTAVES, 3: octaves in pyramid (1..4)
- NUM_SCALES, 4: Gaussian images per octave (2..4); pairs per octave = NUM_SCALES-1
- DIMENSION, 64: side length of octave 0; octave k side = DIMENSION>>k
- TIMEOUT_CYCLES, 16384: watchdog limit (used only with the macro)

Ports:
- clk  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- start_in  in  1  single-cycle request to begin a full sweep
- worker_busy  in  1  busy from the extrema worker
- worker_start  out  1  single-cycle launch pulse to the worker
- octave_out  out  2  current octave index, to BRAM mux
- sharp_sel  out  2  scale index of the sharper image (= pair)
- fuzzy_sel  out  2  scale index of the fuzzier image (= pair+1)
- dim_out  out  $clog2(DIMENSION)+1  side length of the current octave
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse at the end of a sweep
- error_out  out  1  sticky watchdog flag

## Operation
- States: IDLE, SETUP, LAUNCH, WAIT_ACK, RUN, ADVANCE, DONE.
- IDLE: start_in=1 → SETUP. Clears octave and pair to 0 and clears error_out.
- SETUP: holds the selects stable for one cycle so the BRAM mux and read latency settle → LAUNCH.
- LAUNCH: worker_start=1 for exactly one cycle → WAIT_ACK.
- WAIT_ACK: worker_busy=1 → RUN. Stays here while worker_busy=0.
- RUN: worker_busy=0 → ADVANCE.
- ADVANCE:
  - pair < NUM_SCALES-2: pair++ → SETUP.
  - Otherwise pair=0. If octave < NUM_OCTAVES-1: octave++ → SETUP. Otherwise → DONE.
- DONE: done=1 for one cycle → IDLE.
- Selects: sharp_sel=pair, fuzzy_sel=pair+1, dim_out=DIMENSION>>octave. All are registered and change only in ADVANCE or in IDLE on start.
- start_in is ignored in every state except IDLE. It is not queued.
- The total number of launches per sweep is NUM_OCTAVES×(NUM_SCALES-1).

## Timing
- Reset values: busy=0, done=0, worker_start=0, octave_out=0, sharp_sel=0, fuzzy_sel=1, dim_out=DIMENSION, error_out=0. State returns to IDLE.
- Reset mid-sweep aborts immediately. No done pulse is emitted. The worker is not signalled.
- Start accepted at cycle 0 → busy=1 and SETUP at cycle 1. worker_start=1 at cycle 2.
- Worker busy rising at cycle n, falling at cycle m → ADVANCE at m+1 → SETUP at m+2 → next worker_start at m+3.
- Per-pair overhead is 4 cycles plus the worker ack delay.
- On the final pair: ADVANCE at m+1, done=1 at m+2, busy=0 at m+3.
- worker_busy already high in LAUNCH does not count as an ack. Sampling begins in WAIT_ACK.

## Configuration
- DOG_SCHED_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT_ACK+RUN and resets on every LAUNCH.
  - On reaching TIMEOUT_CYCLES the block sets error_out=1 and goes → DONE, which pulses done and then returns to IDLE.
  - error_out holds until the next accepted start.
- DOG_SCHED_TIMEOUT_EN undefined: no counter is instantiated, error_out is tied 0, and the block waits indefinitely.

## Structure
- Package dog_sched_pkg:
  - sched_state_t enum for the 7 states
  - width constants OCT_W=2 and SCALE_W=2
  - the DIM_W function
- Sub-module sched_watchdog: loadable up-counter with a clear input and a terminal-count output. It is instantiated only under DOG_SCHED_TIMEOUT_EN.

## Test plan
- Reset then idle, with no start → all outputs hold the reset values listed above. With defaults: fuzzy_sel=1, dim_out=64.
- Default parameters, worker model that acks in 1 cycle and runs 10 cycles:
  - exactly 9 worker_start pulses
  - (octave,sharp,fuzzy) sequence (0,0,1),(0,1,2),(0,2,3),(1,0,1)…(2,2,3)
  - dim_out sequence 64/32/16
  - one done pulse; busy then drops.
- start_in pulsed while busy, during RUN of pair 1 → ignored. Still 9 launches and a single done.
- Worker holds busy high in LAUNCH and stays high 5 cycles → that high does not count as an ack. Scheduler advances only after busy falls following WAIT_ACK.
- Assert rst_in low during RUN of octave 1 → immediate reset values, no done pulse. A new start restarts at (0,0,1).
- With DOG_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=32, worker never acks:
  - error_out=1 and done pulse 33 cycles after worker_start
  - error_out clears on the next start.
